serial_to_parallel_rx: RTL
==========================

// Module: serial_to_parallel_rx
// PURPOSE
//  Receive-side deserializer of the PHY. Shifts one serial bit per clk_8f cycle,
//  finds byte alignment from the comma (COMMA = 8'hBC), and declares the link
//  active after ACTIVE_CNT aligned commas. Then emits one byte every 8 cycles.
//  Sits directly upstream of the valid/data retiming flops; data_out/valid_out feed them.
// PARAMETERS
//  DATA_W      8      byte width; also the bit-counter period
//  COMMA       8'hBC  idle/alignment symbol
//  ACTIVE_CNT  4      consecutive aligned commas required to enter ACTIVE (>=2)
// PORTS
//  clk_8f     in   1       bit clock; all logic on posedge
//  reset      in   1       synchronous, active-low
//  serial_in  in   1       serial data, MSB of each byte first
//  data_out   out  DATA_W  recovered byte
//  valid_out  out  1       data_out holds a non-comma byte
//  active     out  1       link aligned and in ACTIVE state
// BEHAVIOUR
//  - reset==0 at a posedge: sr=0, bit_cnt=0, bc_cnt=0, state=SEARCH, data_out=0,
//    valid_out=0, active=0. Applies mid-byte or mid-alignment; no partial state kept.
//  - Every cycle: sr <= nxt, where nxt = {sr[DATA_W-2:0], serial_in}. All comma
//    compares use nxt, so a byte is recognised in the cycle its last bit arrives.
//  - bit_cnt: 3-bit, increments every cycle outside SEARCH; wraps 7->0.
//    bit_cnt==7 marks a byte boundary.
//  - SEARCH: bit_cnt is not used. If nxt==COMMA: bc_cnt<=1, bit_cnt<=0, go to ALIGN.
//  - ALIGN, at a boundary:
//    - nxt==COMMA: bc_cnt++. If bc_cnt+1==ACTIVE_CNT, go to ACTIVE and set active<=1.
//    - otherwise: bc_cnt<=0, go to SEARCH.
//    - Outside boundaries, no compare is made.
//  - ACTIVE, at a boundary:
//    - nxt!=COMMA: data_out<=nxt, valid_out<=1.
//    - nxt==COMMA: valid_out<=0; data_out follows CONFIGURATION.
//    - Both outputs hold for the full 8-cycle byte period.
//    - ACTIVE is left only via reset; there is no loss-of-sync exit.
//  - Latency: the last bit of a byte is sampled at posedge N; data_out and
//    valid_out update at that same posedge N (registered).
//  - An arbitrary number of non-comma bytes after ACTIVE is legal. Commas between
//    data deassert valid_out for exactly that byte period.
//  - A comma appearing at a non-boundary bit offset while in ALIGN or ACTIVE is ignored.
// CONFIGURATION
//  RX_IDLE_HOLD_EN defined:
//    - On a comma boundary in ACTIVE, data_out keeps the last data byte.
//  RX_IDLE_HOLD_EN undefined (default):
//    - On a comma boundary in ACTIVE, data_out<=0.
//  - valid_out behaviour is identical in both builds.
// STRUCTURE
//  - Shared package phy_pkg:
//    - rx_state_t enum {SEARCH, ALIGN, ACTIVE} (2 bits)
//    - localparam COMMA_SYM=8'hBC, used as the COMMA default
//    - localparam BYTE_W=8
//  - Single module, no sub-modules. The comma compare is one combinational line,
//    not a separate block.
// TESTING
//  1. Reset: hold reset=0 for 10 cycles while toggling serial_in
//     -> data_out=0, valid_out=0, active=0 throughout.
//  2. Alignment: 3 random bits, then 4x 8'hBC
//     -> active=1 at the posedge sampling the last bit of the 4th BC;
//        valid_out stays 0.
//  3. Data: after case 2, send 8'h5A, 8'hBC, 8'hC3
//     -> valid_out=1 with data_out=5A for 8 cycles; then valid_out=0 for 8 cycles
//        (data_out=00, or 5A with RX_IDLE_HOLD_EN); then valid_out=1 with data_out=C3.
//  4. Broken alignment: BC, BC, 8'h11, BC x4
//     -> return to SEARCH on 8'h11, active rises only at the end of the later 4th BC.
//  5. Reset mid-stream: assert reset=0 during the 3rd bit of a data byte in ACTIVE
//     -> all outputs 0 next posedge; 4 new BCs are needed before active=1.
//  6. Misaligned comma: in ACTIVE, send 8'h0B then 8'hC0 (BC straddles the boundary)
//     -> valid_out=1 with data_out=0B, then valid_out=1 with data_out=C0; active stays 1.

Source files
------------

// File: rtl/phy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : phy_pkg
//  Description : Shared PHY definitions: receiver state encoding, the
//                idle/alignment comma symbol and the byte width.
//  Revision    : 1.0  initial release
// ============================================================================
package phy_pkg;

    // Receiver alignment state machine encoding.
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } rx_state_t;

    localparam logic [7:0] COMMA_SYM = 8'hBC;
    localparam int         BYTE_W    = 8;

endpackage : phy_pkg
`default_nettype wire

// File: rtl/serial_to_parallel_rx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_to_parallel_rx
//  Description : Receive-side deserializer. Shifts in one bit per clk_8f,
//                locks byte alignment on the comma symbol, enters ACTIVE after
//                ACTIVE_CNT aligned commas, then presents one byte every
//                DATA_W cycles.
//  Ports       : clk_8f    - bit clock, all logic on posedge
//                reset     - synchronous, active-low
//                serial_in - serial data, MSB of each byte first
//                data_out  - recovered byte (held for a full byte period)
//                valid_out - data_out holds a non-comma byte
//                active    - link aligned, ACTIVE state
//  Build macro : RX_IDLE_HOLD_EN - when defined, data_out keeps the last data
//                byte across comma periods; otherwise it is cleared to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_to_parallel_rx
    import phy_pkg::*;
#(
    parameter int                DATA_W     = BYTE_W,
    parameter logic [DATA_W-1:0] COMMA      = DATA_W'(COMMA_SYM),
    parameter int                ACTIVE_CNT = 4
) (
    input  logic              clk_8f,
    input  logic              reset,
    input  logic              serial_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              active
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int BC_W  = $clog2(ACTIVE_CNT + 1);

    localparam logic [CNT_W-1:0] C_LAST_BIT   = CNT_W'(DATA_W - 1);
    localparam logic [BC_W-1:0]  C_ACTIVE_CNT = BC_W'(ACTIVE_CNT);

    rx_state_t         r_state;
    rx_state_t         w_state_nxt;
    logic [DATA_W-1:0] r_sr;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [CNT_W-1:0]  w_bit_cnt_nxt;
    logic [BC_W-1:0]   r_bc_cnt;
    logic [BC_W-1:0]   w_bc_cnt_nxt;
    logic [BC_W-1:0]   w_bc_inc;
    logic [DATA_W-1:0] w_data_nxt;
    logic              w_valid_nxt;
    logic              w_active_nxt;

    // Shift-register contents after this cycle's bit; all decisions look at
    // this so a byte is recognised on the same edge its last bit arrives.
    logic [DATA_W-1:0] w_nxt;
    logic              w_is_comma;
    logic              w_boundary;

    assign w_nxt      = {r_sr[DATA_W-2:0], serial_in};
    assign w_is_comma = (w_nxt == COMMA);
    assign w_boundary = (r_bit_cnt == C_LAST_BIT);
    assign w_bc_inc   = r_bc_cnt + BC_W'(1);

    always_ff @(posedge clk_8f) begin
        if (!reset) begin
            r_state   <= SEARCH;
            r_sr      <= '0;
            r_bit_cnt <= '0;
            r_bc_cnt  <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sr      <= w_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_bc_cnt  <= w_bc_cnt_nxt;
            data_out  <= w_data_nxt;
            valid_out <= w_valid_nxt;
            active    <= w_active_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
        w_bc_cnt_nxt  = r_bc_cnt;
        w_data_nxt    = data_out;
        w_valid_nxt   = valid_out;
        w_active_nxt  = active;

        case (r_state)
            SEARCH: begin
                // Bit position is meaningless until a comma fixes it.
                w_bit_cnt_nxt = r_bit_cnt;
                if (w_is_comma) begin
                    w_bc_cnt_nxt  = BC_W'(1);
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = ALIGN;
                end
            end

            ALIGN: begin
                if (w_boundary) begin
                    if (w_is_comma) begin
                        w_bc_cnt_nxt = w_bc_inc;
                        if (w_bc_inc == C_ACTIVE_CNT) begin
                            w_state_nxt  = ACTIVE;
                            w_active_nxt = 1'b1;
                        end
                    end else begin
                        w_bc_cnt_nxt = '0;
                        w_state_nxt  = SEARCH;
                    end
                end
            end

            ACTIVE: begin
                // Outputs only change on byte boundaries, so they hold for
                // the whole byte period. No exit except reset.
                if (w_boundary) begin
                    if (!w_is_comma) begin
                        w_data_nxt  = w_nxt;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_valid_nxt = 1'b0;
`ifdef RX_IDLE_HOLD_EN
                        w_data_nxt  = data_out;
`else
                        w_data_nxt  = '0;
`endif
                    end
                end
            end

            default: begin
                w_state_nxt = SEARCH;
            end
        endcase
    end

endmodule : serial_to_parallel_rx
`default_nettype wire
